// File: rtl/logic_op_pkg.sv
// Shared opcode, response-error and FSM state definitions for the logic-unit dispatcher.
package logic_op_pkg;

  localparam int OP_NOTA = 0;
  localparam int OP_NOTB = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_NAND = 5;
  localparam int OP_NOR  = 6;
  localparam int OP_XNOR = 7;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OP  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  function automatic logic op_legal(input int op, input int num_ops);
    return op < num_ops;
  endfunction

endpackage

// File: rtl/op_req_fifo.sv
// Synchronous request FIFO with full/empty flags; the head entry is visible combinationally.
module op_req_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  // Push depends only on the current full flag, so a same-cycle pop never frees a slot early.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/logic_op_dispatcher.sv
// Queues logic-unit requests and issues them over the start/finish handshake, returning results.
// Optional ISSUE watchdog enabled by defining LOGIC_DISPATCH_TIMEOUT_EN.
module logic_op_dispatcher
  import logic_op_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 4,
  parameter int NUM_OPS     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic [DATA_W-1:0] lu_a,
  output logic [DATA_W-1:0] lu_b,
  output logic [OP_W-1:0]   lu_op,
  output logic              lu_start,
  input  logic              lu_finish,
  input  logic [DATA_W-1:0] lu_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic              busy
);

  localparam int ENT_W = 2*DATA_W + OP_W;

  logic [ENT_W-1:0]  head;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [OP_W-1:0]   head_op;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  state_t            state_reg;
  state_t            state_next;
  logic              load_lu;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;
  logic [1:0]        cap_err;
  logic              timeout_hit;

  logic [DATA_W-1:0] lu_a_reg;
  logic [DATA_W-1:0] lu_b_reg;
  logic [OP_W-1:0]   lu_op_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [1:0]        rsp_err_reg;

  op_req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_valid),
    .din   ({req_a, req_b, req_op}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_a, head_b, head_op} = head;

`ifdef LOGIC_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wdog_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_reg <= '0;
    end else if (load_lu) begin
      wdog_reg <= '0;
    end else if (state_reg == ISSUE) begin
      wdog_reg <= wdog_reg + WD_W'(1);
    end
  end

  // Fires on the last allowed ISSUE cycle, so exactly TIMEOUT_CYC start cycles are spent.
  assign timeout_hit = (state_reg == ISSUE) && (wdog_reg == WD_W'(TIMEOUT_CYC - 1));
`else
  // Never fires; keeps the parameter referenced in builds without the watchdog.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    load_lu    = 1'b0;
    cap_en     = 1'b0;
    cap_data   = '0;
    cap_err    = ERR_OK;
    case (state_reg)
      IDLE: begin
        // A finish seen while idle belongs to an abandoned op and must be cleared first.
        if (lu_finish) begin
          state_next = CLEAR;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (op_legal(int'(head_op), NUM_OPS)) begin
            load_lu    = 1'b1;
            state_next = ISSUE;
          end else begin
            cap_en     = 1'b1;
            cap_err    = ERR_OP;
            state_next = RESP;
          end
        end
      end
      ISSUE: begin
        if (lu_finish) begin
          cap_en     = 1'b1;
          cap_data   = lu_c;
          state_next = RESP;
        end else if (timeout_hit) begin
          cap_en     = 1'b1;
          cap_err    = ERR_TMO;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lu_a_reg     <= '0;
      lu_b_reg     <= '0;
      lu_op_reg    <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= ERR_OK;
    end else begin
      if (load_lu) begin
        lu_a_reg  <= head_a;
        lu_b_reg  <= head_b;
        lu_op_reg <= head_op;
      end
      if (cap_en) begin
        rsp_data_reg <= cap_data;
        rsp_err_reg  <= cap_err;
      end
    end
  end

  assign lu_a      = lu_a_reg;
  assign lu_b      = lu_b_reg;
  assign lu_op     = lu_op_reg;
  assign lu_start  = (state_reg == ISSUE) || (state_reg == CLEAR);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign req_ready = !fifo_full;
  assign busy      = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_logic_op_dispatcher.sv
// Directed bench for logic_op_dispatcher with a 1-cycle start/finish logic-unit model.
module tb_logic_op_dispatcher;
  import logic_op_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_a = '0;
  logic [DATA_W-1:0] req_b = '0;
  logic [OP_W-1:0]   req_op = '0;
  logic [DATA_W-1:0] lu_a;
  logic [DATA_W-1:0] lu_b;
  logic [OP_W-1:0]   lu_op;
  logic              lu_start;
  logic              lu_finish;
  logic [DATA_W-1:0] lu_c;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always #5 clock = ~clock;

  logic_op_dispatcher #(
    .DATA_W(DATA_W), .OP_W(OP_W), .NUM_OPS(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op),
    .lu_start(lu_start), .lu_finish(lu_finish), .lu_c(lu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // Logic-unit model: finish rises one edge after start, clears on start & finish.
  logic        fin_q;
  logic [31:0] c_q;
  bit          model_en = 1'b1;
  bit          inject_stale = 1'b0;

  function automatic logic [31:0] lu_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return ~a;
      4'd1:    return ~b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a & b);
      4'd6:    return ~(a | b);
      4'd7:    return ~(a ^ b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      fin_q <= 1'b0;
      c_q   <= '0;
    end else if (inject_stale) begin
      fin_q <= 1'b1;
    end else if (lu_start && fin_q) begin
      fin_q <= 1'b0;
    end else if (lu_start && model_en) begin
      fin_q <= 1'b1;
      c_q   <= lu_fn(lu_a, lu_b, lu_op);
    end
  end
  assign lu_finish = fin_q;
  assign lu_c      = c_q;

  always @(negedge clock) if (lu_start) start_cnt++;

  initial begin
    #300000;
    $display("FAIL sim_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    check("push_req_ready", 32'(req_ready), 32'd1);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 60) begin
      tick();
      edges++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: rsp_valid=0 after %0d edges, required 1", edges);
    end
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic drain(input string name, input logic [31:0] exp_data, input logic [1:0] exp_err);
    int lat;
    wait_rsp(lat);
    check({name, "_data"}, rsp_data, exp_data);
    check({name, "_err"}, 32'(rsp_err), 32'(exp_err));
    $display("txn %s data=%h err=%0d", name, rsp_data, rsp_err);
    accept();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_starts;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    int s0;
    bit saw_rsp;

    vecs[0]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2,  32'hF000_F000, ERR_OK, 3, 2};
    vecs[1]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0,  32'h0F0F_0F0F, ERR_OK, 3, 2};
    vecs[2]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd1,  32'h00FF_00FF, ERR_OK, 3, 2};
    vecs[3]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3,  32'hFFF0_FFF0, ERR_OK, 3, 2};
    vecs[4]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4,  32'h0FF0_0FF0, ERR_OK, 3, 2};
    vecs[5]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5,  32'h0FFF_0FFF, ERR_OK, 3, 2};
    vecs[6]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6,  32'h000F_000F, ERR_OK, 3, 2};
    vecs[7]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7,  32'hF00F_F00F, ERR_OK, 3, 2};
    vecs[8]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9,  32'h0000_0000, ERR_OP, 1, 0};
    vecs[9]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd8,  32'h0000_0000, ERR_OP, 1, 0};
    vecs[10] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd15, 32'h0000_0000, ERR_OP, 1, 0};
    vecs[11] = '{32'h1234_5678, 32'h0000_FFFF, 4'd4,  32'h1234_A987, ERR_OK, 3, 2};

    // Reset state
    repeat (3) tick();
    check("rst_lu_start", 32'(lu_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lu_a", lu_a, 32'd0);
    check("rst_lu_op", 32'(lu_op), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Single ops: data, error code, latency from push edge, start cycles
    for (int i = 0; i < 12; i++) begin
      s0 = start_cnt;
      push(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_rsp(lat);
      check("vec_data", rsp_data, vecs[i].exp_data);
      check("vec_err", 32'(rsp_err), 32'(vecs[i].exp_err));
      check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
      check("vec_starts", 32'(start_cnt - s0), 32'(vecs[i].exp_starts));
      $display("txn vec%0d op=%0d a=%h b=%h data=%h err=%0d lat=%0d", i, vecs[i].op,
               vecs[i].a, vecs[i].b, rsp_data, rsp_err, lat);
      accept();
      check("vec_rsp_dropped", 32'(rsp_valid), 32'd0);
    end

    // Fill the FIFO behind a stalled response, then drain in order
    push(32'h1234_5678, 32'h0000_FFFF, 4'd2);
    wait_rsp(lat);
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0);
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3);
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4);
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7);
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    req_a = 32'hF0F0_F0F0; req_b = 32'hFF00_FF00; req_op = 4'd5; req_valid = 1'b1;
    tick();
    tick();
    check("full_blocked", 32'(req_ready), 32'd0);
    check("blk_data", rsp_data, 32'h0000_5678);
    $display("txn blocker data=%h err=%0d", rsp_data, rsp_err);
    accept();
    tick();
    req_valid = 1'b0;
    check("after_pop_ready", 32'(req_ready), 32'd1);
    drain("q_op0", 32'h0F0F_0F0F, ERR_OK);
    drain("q_op3", 32'hFFF0_FFF0, ERR_OK);
    drain("q_op4", 32'h0FF0_0FF0, ERR_OK);
    drain("q_op7", 32'hF00F_F00F, ERR_OK);
    saw_rsp = 1'b0;
    repeat (12) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("q_no_extra_rsp", 32'(saw_rsp), 32'd0);
    check("q_idle_busy", 32'(busy), 32'd0);

    // Stale finish while idle: one CLEAR start pulse, then the queued op runs
    inject_stale = 1'b1;
    tick();
    inject_stale = 1'b0;
    s0 = start_cnt;
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6);
    check("clr_start_hi", 32'(lu_start), 32'd1);
    check("clr_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("clr_start_lo", 32'(lu_start), 32'd0);
    wait_rsp(lat);
    check("clr_latency", 32'(lat), 32'd3);
    check("clr_data", rsp_data, 32'h000F_000F);
    check("clr_err", 32'(rsp_err), 32'(ERR_OK));
    check("clr_starts", 32'(start_cnt - s0), 32'd3);
    $display("txn stale_clear data=%h err=%0d lat=%0d", rsp_data, rsp_err, lat + 1);
    accept();

`ifdef LOGIC_DISPATCH_TIMEOUT_EN
    // Watchdog: unit never finishes
    model_en = 1'b0;
    s0 = start_cnt;
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2);
    wait_rsp(lat);
    check("tmo_latency", 32'(lat), 32'd17);
    check("tmo_err", 32'(rsp_err), 32'(ERR_TMO));
    check("tmo_data", rsp_data, 32'd0);
    check("tmo_start", 32'(lu_start), 32'd0);
    check("tmo_starts", 32'(start_cnt - s0), 32'd16);
    $display("txn timeout data=%h err=%0d lat=%0d", rsp_data, rsp_err, lat);
    accept();
    model_en = 1'b1;
`endif

    // Reset during ISSUE abandons the op and the queue
    model_en = 1'b0;
    push(32'hAAAA_5555, 32'h0000_0001, 4'd3);
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2);
    tick();
    check("mid_issue_start", 32'(lu_start), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mr_lu_start", 32'(lu_start), 32'd0);
    check("mr_lu_a", lu_a, 32'd0);
    check("mr_lu_b", lu_b, 32'd0);
    check("mr_lu_op", 32'(lu_op), 32'd0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_rsp_data", rsp_data, 32'd0);
    check("mr_rsp_err", 32'(rsp_err), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    model_en = 1'b1;
    check("mr_req_ready", 32'(req_ready), 32'd1);
    s0 = start_cnt;
    saw_rsp = 1'b0;
    repeat (20) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("mr_no_rsp", 32'(saw_rsp), 32'd0);
    check("mr_no_start", 32'(start_cnt - s0), 32'd0);
    check("mr_fifo_empty", 32'(busy), 32'd0);
    $display("txn reset_mid_issue busy=%0d rsp_seen=%0d", busy, saw_rsp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
